rescale_ctrl: RTL and testbench

Sequencer and flow-control wrapper around the fixed-latency, non-stallable rescale pipeline. Accepts MAC/ADD numbers on a valid/ready stream and feeds them to rescale. Tracks in-flight words with a valid shift register and captures results into a credit-protected output FIFO, so downstream back-pressure never drops data. Owns the shift/head configuration and applies a new configuration only after the pipeline has drained.

---
 rtl/rescale_ctrl.sv | 130 +++++++++++++
 tb/tb_rescale_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rescale_ctrl.sv
// rescale_ctrl: valid/ready wrapper and configuration sequencer around the
// fixed-latency, non-stallable rescale pipeline. In-flight words are tracked
// with a valid shift register; results land in a credit-protected FIFO so
// downstream back-pressure never loses data. A new shift/head configuration
// is applied only once the pipeline has drained.
module rescale_ctrl #(
  parameter int NUM_WIDTH   = 33,
  parameter int IMG_WIDTH   = 16,
  parameter int LATENCY     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AWIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_shift,
  input  logic [7:0]           cfg_head,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic [NUM_WIDTH-1:0] rs_data,
  output logic [7:0]           rs_shift,
  output logic [7:0]           rs_head,
  input  logic [IMG_WIDTH-1:0] rs_result,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [IMG_WIDTH-1:0] dn_data,
  output logic                 busy
);

  // Wide enough to hold inflight + fifo_count (each bounded by FIFO_DEPTH).
  localparam int CNT_W = FIFO_AWIDTH + 2;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [LATENCY-1:0]     vpipe;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       credit_used;
  logic [FIFO_AWIDTH-1:0] wr_ptr;
  logic [FIFO_AWIDTH-1:0] rd_ptr;
  logic [IMG_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                   accept;
  logic                   fifo_wr;
  logic                   fifo_rd;

  assign rs_data = up_data;

  // Credits: every accepted word is guaranteed a FIFO slot when it emerges.
  assign credit_used = inflight + fifo_count;
  assign up_ready    = (state == ST_RUN) && !cfg_valid &&
                       (credit_used < CNT_W'(FIFO_DEPTH));
  assign accept      = up_valid && up_ready;

  assign fifo_wr   = vpipe[LATENCY-1];
  assign dn_valid  = (fifo_count != '0);
  assign fifo_rd   = dn_valid && dn_ready;
  assign dn_data   = dn_valid ? mem[rd_ptr] : '0;
  assign cfg_ready = (state == ST_UPDATE);
  assign busy      = (inflight != '0) || (fifo_count != '0);

  // Next-state logic for the configuration sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (cfg_valid) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (inflight == '0) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Sequencer state and the registered configuration driven into rescale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      rs_shift <= '0;
      rs_head  <= 8'(IMG_WIDTH - 1);
    end else begin
      state <= state_nxt;
      if (state == ST_UPDATE) begin
        rs_shift <= cfg_shift;
        rs_head  <= cfg_head;
      end
    end
  end

  // Valid shift register mirroring words travelling through rescale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      vpipe <= {vpipe[LATENCY-2:0], accept};
      case ({accept, vpipe[LATENCY-1]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy; a read on empty is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= rs_result;
  end

endmodule

// File: tb/tb_rescale_ctrl.sv
// Testbench for rescale_ctrl: a behavioural rescale pipeline stub, a
// scoreboard fed at accept time and a monitor popping on each dn handshake.
module tb_rescale_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_shift, cfg_head;
  logic        up_valid, up_ready;
  logic [32:0] up_data, rs_data;
  logic [7:0]  rs_shift, rs_head;
  logic [15:0] rs_result;
  logic        dn_valid, dn_ready;
  logic [15:0] dn_data;
  logic        busy;

  rescale_ctrl #(
    .NUM_WIDTH(33), .IMG_WIDTH(16), .LATENCY(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_shift(cfg_shift), .cfg_head(cfg_head),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .rs_data(rs_data), .rs_shift(rs_shift), .rs_head(rs_head),
    .rs_result(rs_result),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic right shift of the sign-extended number.
  function automatic longint shift_part(input logic [32:0] d, input logic [7:0] s);
    longint v;
    v = longint'($signed(d));
    return v >>> s;
  endfunction

  // Saturate to the signed range given by head, then to 16-bit signed.
  function automatic logic [15:0] sat_part(input longint v, input logic [7:0] h);
    longint lim, r;
    int hh;
    hh  = (h > 8'd30) ? 30 : int'(h);
    lim = longint'(1) << hh;
    r   = v;
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [15:0] ref_rescale(input logic [32:0] d,
                                              input logic [7:0] s,
                                              input logic [7:0] h);
    return sat_part(shift_part(d, s), h);
  endfunction

  // Rescale stub: 4 edges from sampling rs_data to rs_result; shift sampled
  // with the data, head one edge later.
  longint      p0;
  logic [15:0] p1, p2, p3;
  always @(posedge clk) begin
    p0 <= shift_part(rs_data, rs_shift);
    p1 <= sat_part(p0, rs_head);
    p2 <= p1;
    p3 <= p2;
  end
  assign rs_result = p3;

  logic [15:0] exp_q[$];
  int          acc_cyc[$];
  int          pop_cyc[$];
  logic [7:0]  cur_shift = 8'd0;
  logic [7:0]  cur_head  = 8'd15;
  bit          acc_now;
  bit          cfg_hit;
  int          cfg_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream handshake.
  always @(negedge clk) begin
    if (rst_n && dn_valid && dn_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_word actual=%0h expected=none (cycle %0d)", dn_data, cyc);
      end else begin
        chk("dn_data", {48'd0, dn_data}, {48'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock: observe handshakes at negedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    acc_now = 1'b0;
    if (rst_n && up_valid && up_ready) begin
      exp_q.push_back(ref_rescale(up_data, cur_shift, cur_head));
      acc_cyc.push_back(cyc);
      acc_now = 1'b1;
    end
    if (rst_n && cfg_ready) begin
      cur_shift = cfg_shift;
      cur_head  = cfg_head;
      cfg_hit   = 1'b1;
      cfg_cyc   = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [32:0] w);
    up_valid = 1'b1;
    up_data  = w;
    acc_now  = 1'b0;
    for (int i = 0; i < 200 && !acc_now; i++) step();
    if (!acc_now) chk("send_timeout", 64'd0, 64'd1);
    up_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    dn_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_cfg(input logic [7:0] s, input logic [7:0] h, input bit rand_up);
    cfg_valid = 1'b1;
    cfg_shift = s;
    cfg_head  = h;
    cfg_hit   = 1'b0;
    for (int i = 0; i < 100 && !cfg_hit; i++) begin
      if (rand_up) begin
        up_valid = ($urandom_range(1, 0) == 1);
        up_data  = {1'($urandom), 32'($urandom)};
        dn_ready = ($urandom_range(3, 0) != 0);
      end
      step();
    end
    chk("cfg_timeout", 64'(cfg_hit), 64'd1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, n;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_shift = '0; cfg_head = '0;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dn_data", 64'(dn_data), 64'd0);
    chk("rst_rs_shift", 64'(rs_shift), 64'd0);
    chk("rst_rs_head", 64'(rs_head), 64'd15);
    rst_n = 1'b1;
    step();
    chk("idle_up_ready", 64'(up_ready), 64'd1);

    // Directed stream, latency and throughput.
    dn_ready = 1'b1;
    acc_cyc.delete(); pop_cyc.delete();
    send(33'h0_0000_0012);
    send(33'h0_0000_0034);
    send(33'h0_0000_7FFF);
    drain();
    chk("lat_first", 64'(pop_cyc[0]), 64'(acc_cyc[0] + 5));
    chk("thru_second", 64'(pop_cyc[1]), 64'(pop_cyc[0] + 1));
    chk("thru_third", 64'(pop_cyc[2]), 64'(pop_cyc[1] + 1));

    // New config, saturating and in-range values.
    do_cfg(8'd4, 8'd19, 1'b0);
    chk("cfg_shift_applied", 64'(rs_shift), 64'd4);
    chk("cfg_head_applied", 64'(rs_head), 64'd19);
    send(33'h0_000F_0000);
    send(33'h0_0000_1230);
    send(33'h1_FFFF_0000);
    drain();

    // Back-pressure: credits limit acceptance to the FIFO depth.
    dn_ready = 1'b0;
    up_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      up_data = {1'($urandom), 32'($urandom)};
      step();
      if (acc_now) n++;
    end
    chk("credit_accepts", 64'(n), 64'd8);
    chk("full_up_ready", 64'(up_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    dn_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      up_data = {1'($urandom), 32'($urandom)};
      step();
      if (acc_now) n++;
    end
    chk("credits_return", 64'(n > 0), 64'd1);
    up_valid = 1'b0;
    drain();

    // Config request with three words in flight.
    acc_cyc.delete();
    send(33'h0_0001_0000);
    send(33'h1_FFFF_F000);
    send(33'h0_0000_0ABC);
    a = acc_cyc[2];
    cfg_valid = 1'b1; cfg_shift = 8'd2; cfg_head = 8'd12;
    up_valid = 1'b1; up_data = 33'h0_0000_4000;
    #1;
    chk("cfg_blocks_up", 64'(up_ready), 64'd0);
    cfg_hit = 1'b0;
    for (int i = 0; i < 50 && !cfg_hit; i++) step();
    chk("cfg_ready_cycle", 64'(cfg_cyc), 64'(a + 6));
    cfg_valid = 1'b0;
    chk("cfg_ready_pulse", 64'(cfg_ready), 64'd0);
    acc_now = 1'b0;
    for (int i = 0; i < 20 && !acc_now; i++) step();
    chk("post_cfg_accept", 64'(acc_now), 64'd1);
    up_valid = 1'b0;
    drain();

    // Simultaneous cfg and up on an idle pipeline.
    cfg_valid = 1'b1; cfg_shift = 8'd3; cfg_head = 8'd10;
    up_valid = 1'b1; up_data = 33'h0_0000_2468;
    cfg_hit = 1'b0; n = 0;
    for (int i = 0; i < 20 && !cfg_hit; i++) begin
      step();
      if (acc_now || busy) n++;
    end
    chk("prio_no_accept", 64'(n), 64'd0);
    chk("prio_cfg_done", 64'(cfg_hit), 64'd1);
    cfg_valid = 1'b0;
    acc_now = 1'b0;
    for (int i = 0; i < 20 && !acc_now; i++) step();
    chk("prio_accept_after", 64'(acc_now), 64'd1);
    chk("prio_busy", 64'(busy), 64'd1);
    up_valid = 1'b0;
    drain();
    chk("prio_idle", 64'(busy), 64'd0);

    // Random traffic with occasional reconfiguration.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 100; i++) begin
        up_valid = ($urandom_range(3, 0) != 0);
        up_data  = {1'($urandom), 32'($urandom)};
        dn_ready = ($urandom_range(3, 0) != 0);
        step();
      end
      do_cfg(8'($urandom_range(8, 0)), 8'($urandom_range(20, 8)), 1'b1);
    end
    up_valid = 1'b0;
    drain();

    // Reset with a full FIFO discards everything.
    do_cfg(8'd1, 8'd14, 1'b0);
    dn_ready = 1'b0;
    up_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      up_data = {1'($urandom), 32'($urandom)};
      step();
    end
    up_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cur_shift = 8'd0; cur_head = 8'd15;
    chk("mid_rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rs_shift", 64'(rs_shift), 64'd0);
    chk("mid_rst_rs_head", 64'(rs_head), 64'd15);
    repeat (2) step();
    rst_n = 1'b1;
    dn_ready = 1'b1;
    repeat (12) step();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_dn_valid", 64'(dn_valid), 64'd0);
    send(33'h0_0000_0055);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
